// File: rtl/conv2_k_mem_write_if.sv
// Weight-load bus for conv2_k_mem_write.
// Groups the loader stream handshake (in_valid/in_data/in_ready) with the
// weight-memory write port (we/addr/wdata).
//   master : the loader / memory side (drives in_valid, in_data).
//   slave  : conv2_k_mem_write (drives in_ready, we, addr, wdata).
interface conv2_k_mem_write_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              we;
    logic [7:0]        addr;
    logic [DATA_W-1:0] wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, we, addr, wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, we, addr, wdata
    );
endinterface

// File: rtl/conv2_k_mem_write.sv
// conv2_k_mem_write: streams TAPS*KERNELS weight words from a valid/ready
// loader into the weight memory at strictly sequential addresses
// (kernel k occupies k*TAPS .. k*TAPS+TAPS-1).
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high reset
//   start      - one-cycle pulse that begins a run (ignored while busy)
//   bus        - slave side of the loader stream + memory write port;
//                writes appear one cycle after each accepted word
//   kernel_idx - kernel of the next word to be accepted
//   tap_idx    - tap of the next word to be accepted
//   busy       - run in progress (LOAD or FLUSH)
//   done       - all words of the run written; held until next start
module conv2_k_mem_write #(
    parameter int DATA_W  = 16,
    parameter int TAPS    = 25,
    parameter int KERNELS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    conv2_k_mem_write_if.slave  bus,
    output logic [2:0]          kernel_idx,
    output logic [4:0]          tap_idx,
    output logic                busy,
    output logic                done
);
    localparam int TOTAL = TAPS * KERNELS;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        word_cnt;
    logic [7:0]        addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              accept;
    logic              last_word;
    logic [7:0]        addr_calc;

    assign accept    = bus.in_valid && (state == LOAD);
    assign last_word = (word_cnt == 8'(TOTAL - 1));
    assign addr_calc = 8'(kernel_idx) * 8'(TAPS) + 8'(tap_idx);

    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                if (accept && last_word) state_nxt = FLUSH;
            end
            FLUSH: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters name the next word to accept; the registered write uses the
    // pre-increment values. After the final word the counters hold, so no
    // out-of-range address can ever be formed.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            kernel_idx <= '0;
            tap_idx    <= '0;
            word_cnt   <= '0;
        end else begin
            we_q <= accept;
            if (accept) begin
                addr_q  <= addr_calc;
                wdata_q <= bus.in_data;
                if (!last_word) begin
                    word_cnt <= word_cnt + 8'd1;
                    if (tap_idx == 5'(TAPS - 1)) begin
                        tap_idx    <= '0;
                        kernel_idx <= kernel_idx + 3'd1;
                    end else begin
                        tap_idx <= tap_idx + 5'd1;
                    end
                end
            end else if (start && (state == IDLE || state == DONE)) begin
                kernel_idx <= '0;
                tap_idx    <= '0;
                word_cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_conv2_k_mem_write.sv
module tb_conv2_k_mem_write;
    localparam int TOTAL = 150;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] kernel_idx;
    logic [4:0] tap_idx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [7:0]  log_addr[$];
    logic [15:0] log_data[$];

    always #5 clk = ~clk;

    conv2_k_mem_write_if #(.DATA_W(16)) bus ();

    conv2_k_mem_write #(
        .DATA_W (16),
        .TAPS   (25),
        .KERNELS(6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus.slave),
        .kernel_idx(kernel_idx),
        .tap_idx   (tap_idx),
        .busy      (busy),
        .done      (done)
    );

    // Record every memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            log_addr.push_back(bus.addr);
            log_data.push_back(bus.wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [35:0] obs;
        reset = 1'b1; start = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 16'hFFFF;
        step(); step();
        obs = {bus.in_ready, bus.we, bus.addr, bus.wdata, kernel_idx, tap_idx, busy, done};
        checks++;
        if (obs !== 36'h0) begin
            errors++; $display("FAIL reset_state got %09h exp 000000000", obs);
        end
        reset = 1'b0; start = 1'b0; bus.in_valid = 1'b0;
        step();
        checks++;
        if ({bus.in_ready, busy, done, bus.we} !== 4'b0000) begin
            errors++; $display("FAIL idle_after_reset got %04b exp 0000", {bus.in_ready, busy, done, bus.we});
        end
    endtask

    task automatic test_stream();
        log_addr.delete(); log_data.delete();
        start = 1'b1; step(); start = 1'b0;
        checks++;
        if ({busy, bus.in_ready, done} !== 3'b110) begin
            errors++; $display("FAIL stream_start got %03b exp 110", {busy, bus.in_ready, done});
        end
        for (int i = 0; i < TOTAL; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 16'(i);
            step();
            checks++;
            if ({bus.in_ready, bus.we, bus.addr} !== {(i != TOTAL - 1), 1'b1, 8'(i)}) begin
                errors++;
                $display("FAIL stream_write[%0d] got rdy/we/addr %0b/%0b/%0d exp %0b/1/%0d",
                         i, bus.in_ready, bus.we, bus.addr, (i != TOTAL - 1), i);
            end
            if (i == 24) begin
                checks++;
                if ({kernel_idx, tap_idx} !== {3'd1, 5'd0}) begin
                    errors++; $display("FAIL tap_wrap got k%0d t%0d exp k1 t0", kernel_idx, tap_idx);
                end
            end
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if ({done, busy, bus.we} !== 3'b100) begin
            errors++; $display("FAIL stream_done got done/busy/we %03b exp 100", {done, busy, bus.we});
        end
        step();
        checks++;
        if (done !== 1'b1 || log_addr.size() != TOTAL) begin
            errors++; $display("FAIL stream_count got done %0b writes %0d exp 1 %0d", done, log_addr.size(), TOTAL);
        end
        for (int j = 0; j < log_addr.size(); j++) begin
            checks++;
            if (log_addr[j] !== 8'(j) || log_data[j] !== 16'(j)) begin
                errors++; $display("FAIL stream_log[%0d] got %0d/%0h exp %0d/%0h", j, log_addr[j], log_data[j], j, j);
            end
        end
    endtask

    task automatic test_restart();
        log_addr.delete(); log_data.delete();
        start = 1'b1; step(); start = 1'b0;
        checks++;
        if ({done, busy, bus.in_ready, kernel_idx, tap_idx} !== {1'b0, 1'b1, 1'b1, 3'd0, 5'd0}) begin
            errors++; $display("FAIL restart got done/busy/rdy %0b/%0b/%0b k%0d t%0d exp 0/1/1 k0 t0",
                               done, busy, bus.in_ready, kernel_idx, tap_idx);
        end
        for (int i = 0; i < TOTAL; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 16'hA000 | 16'(i);
            step();
        end
        bus.in_valid = 1'b0;
        step(); step();
        checks++;
        if (log_addr.size() != TOTAL || done !== 1'b1) begin
            errors++; $display("FAIL restart_count got writes %0d done %0b exp %0d 1", log_addr.size(), done, TOTAL);
        end
        for (int j = 0; j < log_addr.size(); j++) begin
            checks++;
            if (log_addr[j] !== 8'(j) || log_data[j] !== (16'hA000 | 16'(j))) begin
                errors++; $display("FAIL restart_log[%0d] got %0d/%0h exp %0d/%0h", j, log_addr[j], log_data[j], j, 16'hA000 | 16'(j));
            end
        end
    endtask

    task automatic test_bubbles();
        int n;
        int cyc;
        logic v;
        log_addr.delete(); log_data.delete();
        start = 1'b1; step(); start = 1'b0;
        n = 0; cyc = 0;
        while (n < TOTAL && cyc < 1000) begin
            v = (cyc < 80) ? ((cyc % 2) == 0) : 1'b1;
            bus.in_valid = v; bus.in_data = 16'h5000 + 16'(n);
            step();
            if (v) begin
                checks++;
                if (bus.we !== 1'b1 || bus.addr !== 8'(n)) begin
                    errors++; $display("FAIL bubble_write[%0d] got we %0b addr %0d exp 1 %0d", n, bus.we, bus.addr, n);
                end
                n++;
            end else begin
                checks++;
                if (bus.we !== 1'b0) begin
                    errors++; $display("FAIL bubble_stall[%0d] got we %0b exp 0", cyc, bus.we);
                end
            end
            if (n < TOTAL) begin
                checks++;
                if ({kernel_idx, tap_idx} !== {3'(n / 25), 5'(n % 25)}) begin
                    errors++; $display("FAIL bubble_idx[%0d] got k%0d t%0d exp k%0d t%0d",
                                       n, kernel_idx, tap_idx, n / 25, n % 25);
                end
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        step(); step();
        checks++;
        if (log_addr.size() != TOTAL || done !== 1'b1) begin
            errors++; $display("FAIL bubble_count got writes %0d done %0b exp %0d 1", log_addr.size(), done, TOTAL);
        end
        for (int j = 0; j < log_addr.size(); j++) begin
            checks++;
            if (log_addr[j] !== 8'(j) || log_data[j] !== (16'h5000 + 16'(j))) begin
                errors++; $display("FAIL bubble_log[%0d] got %0d/%0h exp %0d/%0h", j, log_addr[j], log_data[j], j, 16'h5000 + 16'(j));
            end
        end
    endtask

    task automatic test_ignored_start();
        log_addr.delete(); log_data.delete();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < TOTAL; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 16'h7700 + 16'(i);
            start = (i == 40);
            step();
            start = 1'b0;
            if (i == 40) begin
                checks++;
                if ({busy, kernel_idx, tap_idx, bus.addr} !== {1'b1, 3'd1, 5'd16, 8'd40}) begin
                    errors++; $display("FAIL ignored_start got busy %0b k%0d t%0d addr %0d exp 1 k1 t16 40",
                                       busy, kernel_idx, tap_idx, bus.addr);
                end
            end
        end
        // Start also arrives during FLUSH; it must not restart the run.
        bus.in_valid = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if ({done, busy, bus.we} !== 3'b100) begin
            errors++; $display("FAIL flush_start got done/busy/we %03b exp 100", {done, busy, bus.we});
        end
        checks++;
        if (log_addr.size() != TOTAL) begin
            errors++; $display("FAIL ignored_count got %0d exp %0d", log_addr.size(), TOTAL);
        end
        for (int j = 0; j < log_addr.size(); j++) begin
            checks++;
            if (log_addr[j] !== 8'(j) || log_data[j] !== (16'h7700 + 16'(j))) begin
                errors++; $display("FAIL ignored_log[%0d] got %0d/%0h exp %0d/%0h", j, log_addr[j], log_data[j], j, 16'h7700 + 16'(j));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [35:0] obs;
        log_addr.delete(); log_data.delete();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 16'h3300 + 16'(i);
            step();
        end
        reset = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'h3364; start = 1'b1;
        step();
        obs = {bus.in_ready, bus.we, bus.addr, bus.wdata, kernel_idx, tap_idx, busy, done};
        checks++;
        if (obs !== 36'h0) begin
            errors++; $display("FAIL reset_mid got %09h exp 000000000", obs);
        end
        reset = 1'b0; start = 1'b0; bus.in_valid = 1'b0;
        step();
        checks++;
        if (log_addr.size() != 100 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_writes got %0d busy %0b exp 100 0", log_addr.size(), busy);
        end
        log_addr.delete(); log_data.delete();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < TOTAL; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 16'hC000 + 16'(i);
            step();
        end
        bus.in_valid = 1'b0;
        step(); step();
        checks++;
        if (log_addr.size() != TOTAL || done !== 1'b1) begin
            errors++; $display("FAIL rerun_count got writes %0d done %0b exp %0d 1", log_addr.size(), done, TOTAL);
        end
        for (int j = 0; j < log_addr.size(); j++) begin
            checks++;
            if (log_addr[j] !== 8'(j) || log_data[j] !== (16'hC000 + 16'(j))) begin
                errors++; $display("FAIL rerun_log[%0d] got %0d/%0h exp %0d/%0h", j, log_addr[j], log_data[j], j, 16'hC000 + 16'(j));
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_stream();
        test_restart();
        test_bubbles();
        test_ignored_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv2_k_mem_write.md
CONV2_K_MEM_WRITE -- requirements
Module: conv2_k_mem_write

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, weight word width.
REQ-002 SHALL provide parameter TAPS, default 25, weights per kernel (5x5).
REQ-003 SHALL provide parameter KERNELS, default 6, kernels loaded per run; total words = TAPS*KERNELS = 150.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a load run.
REQ-007 in_valid  input  1  source has a weight word on in_data.
REQ-008 in_data  input  DATA_W  weight word from the loader stream.
REQ-009 in_ready  output  1  block accepts a word this cycle.
REQ-010 we  output  1  weight memory write enable.
REQ-011 addr  output  8  weight memory write address.
REQ-012 wdata  output  DATA_W  weight memory write data.
REQ-013 kernel_idx  output  3  kernel currently being loaded, 0..KERNELS-1.
REQ-014 tap_idx  output  5  tap within the current kernel, 0..TAPS-1.
REQ-015 busy  output  1  high while a run is in progress.
REQ-016 done  output  1  high after all words of a run have been written.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, FLUSH, DONE.
REQ-018 IDLE: start=1 -> LOAD, with tap_idx=0, kernel_idx=0, and word counter=0.
REQ-019 LOAD: in_ready SHALL be 1 combinationally; in all other states in_ready SHALL be 0.
REQ-020 A word SHALL be accepted only on an edge where in_valid=1 and in_ready=1.
REQ-021 An accepted word SHALL be registered; we=1, wdata=in_data and addr=kernel_idx*TAPS+tap_idx SHALL appear in the next cycle (latency 1).
REQ-022 we SHALL be 0 in any cycle that follows an edge with no accepted word; in_valid=0 stalls the block with no address advance.
REQ-023 On each accept, tap_idx SHALL increment; at tap_idx=TAPS-1 it SHALL wrap to 0 and kernel_idx SHALL increment.
REQ-024 On accepting word TAPS*KERNELS-1 (kernel_idx=KERNELS-1, tap_idx=TAPS-1) the FSM SHALL go LOAD -> FLUSH; in_ready SHALL drop in that next cycle.
REQ-025 FLUSH SHALL last exactly one cycle, presenting the last write (addr=149), then go to DONE.
REQ-026 DONE: done=1, busy=0, we=0; the FSM SHALL hold until start=1, which restarts the run per REQ-018 (done drops next cycle).
REQ-027 busy SHALL be 1 in LOAD and FLUSH and 0 in IDLE and DONE.
REQ-028 start while in LOAD or FLUSH SHALL be ignored; counters and address sequence SHALL NOT be disturbed.
REQ-029 Address arithmetic SHALL be unsigned, 8 bits; addresses outside 0..149 SHALL never be driven with we=1.
REQ-030 Addresses SHALL be strictly sequential 0,1,...,149 per run, matching the reader layout: kernel k occupies k*25..k*25+24.

Reset
REQ-031 On reset=1 at a clock edge: state=IDLE; in_ready=0, we=0, addr=0, wdata=0, kernel_idx=0, tap_idx=0, busy=0, done=0.
REQ-032 Reset SHALL take priority over start and any handshake on the same edge.
REQ-033 Reset mid-run SHALL abandon the run; no write SHALL be issued in the cycle after the reset edge, and a new start SHALL begin again at addr 0.

Verification
REQ-034 Continuous stream: start, in_valid=1 for 150 cycles, in_data=word index -> 150 writes, addr=data=0..149, one per cycle; done=1 two cycles after the last accept.
REQ-035 Bubbles: in_valid toggled 1,0,1,0 -> we pulses only after accepted edges; addr skips nothing; tap_idx wraps 24->0 at addr 24->25 with kernel_idx 0->1.
REQ-036 Boundary: last accept (kernel_idx=5, tap_idx=24) -> next cycle we=1, addr=149, in_ready=0; following cycle done=1, we=0.
REQ-037 Ignored start: start pulsed at word 40 -> sequence continues 41,42,...; total write count remains 150.
REQ-038 Reset mid-run: reset at word 100 -> all outputs at reset values next cycle, no write; start then re-runs from addr 0 to 149.
REQ-039 Restart from DONE: start while done=1 -> done=0, busy=1, in_ready=1 next cycle; second run reproduces addr 0..149.
